// File: rtl/payload_egress_reader.sv
// payload_egress_reader
//
// Egress-side master on the payload read bus. It takes one packet descriptor
// at a time from the dispatcher, reads the packet from payload storage one
// word per cycle, and streams the words out on a valid/ready interface with
// start-of-packet and end-of-packet markers. A small registered FIFO sits
// between the read bus and the egress port. Reads are only issued when that
// FIFO can take the word, so back-pressure never costs a word. This matters
// most for destructive reads, where storage frees each word as it is read.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   req_valid/req_ready     descriptor handshake
//   req_address             first word address of the packet
//   req_destructive         free words in storage as they are read
//   payload_isFirst         read bus: this read is the first word of a packet
//   payload_address         read bus: word address
//   payload_isDestructive   read bus: free the word being read
//   payload_data            read bus: word data (combinational response)
//   payload_byteCount       read bus: valid bytes in the word
//   payload_isLast          read bus: this word ends the packet
//   out_valid/out_ready     egress word handshake
//   out_data                payload word
//   out_byte_count          valid bytes in the word
//   out_sop, out_eop        first / last word of the packet
//   err_overrun             one-cycle pulse when a packet is cut at MAX_WORDS
//
// FIFO_DEPTH is meant to be 2..8.

module payload_egress_reader #(
    parameter int MAX_WORDS        = 256,
    parameter int FIFO_DEPTH       = 2,
    parameter int ADDR_WIDTH       = 8,
    parameter int DATA_WIDTH       = 64,
    parameter int BYTE_COUNT_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_address,
    input  logic                        req_destructive,
    output logic                        payload_isFirst,
    output logic [ADDR_WIDTH-1:0]       payload_address,
    output logic                        payload_isDestructive,
    input  logic [DATA_WIDTH-1:0]       payload_data,
    input  logic [BYTE_COUNT_WIDTH-1:0] payload_byteCount,
    input  logic                        payload_isLast,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [BYTE_COUNT_WIDTH-1:0] out_byte_count,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        err_overrun
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WCNT_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]       data;
        logic [BYTE_COUNT_WIDTH-1:0] byteCount;
        logic                        sop;
        logic                        eop;
    } fifoEntry_t;

    state_t              stateReg;
    state_t              stateNext;

    logic [ADDR_WIDTH-1:0] curAddr;
    logic                  destructiveFlag;
    logic                  firstFlag;
    logic [WCNT_W-1:0]     wordCnt;

    fifoEntry_t            fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W-1:0]      wrPtr;
    logic [CNT_W-1:0]      fifoCount;

    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  popEn;
    logic                  issueEn;
    logic                  overrunHit;
    fifoEntry_t            pushEntry;
    fifoEntry_t            headEntry;

    // Pointer wrap that also works when FIFO_DEPTH is not a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (fifoCount == '0);
    assign popEn     = !fifoEmpty && out_ready;

    // A read is only issued when its word is guaranteed a FIFO slot. With a
    // full FIFO that means a pop is happening in the same cycle.
    assign issueEn    = (stateReg == READ) && (!fifoFull || popEn);
    assign overrunHit = issueEn && !payload_isLast &&
                        (wordCnt == WCNT_W'(MAX_WORDS - 1));

    assign pushEntry.data      = payload_data;
    assign pushEntry.byteCount = payload_byteCount;
    assign pushEntry.sop       = firstFlag;
    assign pushEntry.eop       = payload_isLast || overrunHit;

    // The bus qualifiers are gated by issueEn. A stalled cycle then never
    // frees a word, and it never marks a packet start twice.
    assign payload_address       = curAddr;
    assign payload_isFirst       = issueEn && firstFlag;
    assign payload_isDestructive = issueEn && destructiveFlag;
    assign err_overrun           = overrunHit;

    assign headEntry      = fifoMem[rdPtr];
    assign out_valid      = !fifoEmpty;
    assign out_data       = headEntry.data;
    assign out_byte_count = headEntry.byteCount;
    assign out_sop        = !fifoEmpty && headEntry.sop;
    assign out_eop        = !fifoEmpty && headEntry.eop;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next state and descriptor handshake. A packet ends on the word that
    // storage flags as last, or on a forced cut at MAX_WORDS.
    always_comb begin
        stateNext = stateReg;
        req_ready = 1'b0;
        case (stateReg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stateNext = READ;
                end
            end
            READ: begin
                if (issueEn && (payload_isLast || overrunHit)) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Packet walk context. It is loaded on descriptor accept and advanced on
    // every issued read. The address wraps naturally at the top of the space.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curAddr         <= '0;
            destructiveFlag <= 1'b0;
            firstFlag       <= 1'b0;
            wordCnt         <= '0;
        end else if (stateReg == IDLE && req_valid) begin
            curAddr         <= req_address;
            destructiveFlag <= req_destructive;
            firstFlag       <= 1'b1;
            wordCnt         <= '0;
        end else if (issueEn) begin
            curAddr   <= curAddr + ADDR_WIDTH'(1);
            firstFlag <= 1'b0;
            wordCnt   <= wordCnt + WCNT_W'(1);
        end
    end

    // FIFO storage. It holds no control state, so it needs no reset; the
    // occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (issueEn) begin
            fifoMem[wrPtr] <= pushEntry;
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave
    // the count unchanged, including when the FIFO is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (issueEn) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (popEn) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({issueEn, popEn})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

endmodule
